// File: rtl/ntt_iter_pkg.sv
// Shared constants and elaboration-time helpers for the iterative forward NTT.
// Twiddle tables are computed from PSI so the forward and inverse tables always agree.
package ntt_iter_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int unsigned Q_DEF = 7681;
   // Primitive 16th root of unity mod 7681 (PSI^8 == Q-1), sized for the D=8 build.
   localparam longint unsigned PSI = 7154;

   function automatic int stages(input int d);
      return $clog2(d);
   endfunction

   function automatic int unsigned bitrev(input int unsigned x, input int bits);
      int unsigned r;
      r = 0;
      for (int i = 0; i < bits; i++) r = (r << 1) | ((x >> i) & 1);
      return r;
   endfunction

   function automatic longint unsigned modpow(input longint unsigned base, input int unsigned e,
                                              input longint unsigned q);
      longint unsigned r;
      longint unsigned bb;
      r  = 1;
      bb = base % q;
      for (int i = 0; i < 32; i++) begin
         if (e[i]) r = (r * bb) % q;
         bb = (bb * bb) % q;
      end
      return r;
   endfunction

   function automatic longint unsigned psi_tab_val(input int unsigned i, input int s);
      return modpow(PSI, bitrev(i, s), longint'(Q_DEF));
   endfunction

   // PSI has order 2^(s+1), so the inverse power is that order minus the forward exponent.
   function automatic longint unsigned psi_inv_tab_val(input int unsigned i, input int s);
      return modpow(PSI, (2 << s) - bitrev(i, s), longint'(Q_DEF));
   endfunction

   // Low index of butterfly m in stage s of an stg-stage transform.
   function automatic int pair_lo(input int m, input int s, input int stg);
      int t;
      t = 1 << (stg - 1 - s);
      return (m / t) * 2 * t + (m % t);
   endfunction

endpackage

// File: rtl/ntt_iter_if.sv
// Start/busy/done handshake and coefficient buses of the forward NTT.
interface ntt_iter_if #(
   parameter int N = 17,
   parameter int D = 8
);
   logic           start;
   logic [D*N-1:0] a;
   logic           busy;
   logic           done;
   logic [D*N-1:0] b;

   modport master (output start, output a, input busy, input done, input b);
   modport slave  (input start, input a, output busy, output done, output b);
endinterface

// File: rtl/ntt_iter_butterfly.sv
// Combinational Cooley-Tukey butterfly: (u + v*w, u - v*w), both reduced mod Q.
module ntt_butterfly #(
   parameter int N = 17,
   parameter int Q = 7681
) (
   input  logic [N-1:0] u,
   input  logic [N-1:0] v,
   input  logic [N-1:0] w,
   output logic [N-1:0] sum,
   output logic [N-1:0] diff
);
   localparam logic [2*N-1:0] QW = (2*N)'(Q);
   localparam logic [N:0]     QS = (N+1)'(Q);

   logic [2*N-1:0] prod;
   logic [N-1:0]   vw;
   logic [N:0]     sum_raw;

   assign prod    = (2*N)'(v) * (2*N)'(w);
   assign vw      = N'(prod % QW);
   assign sum_raw = {1'b0, u} + {1'b0, vw};
   assign sum     = (sum_raw >= QS) ? N'(sum_raw - QS) : sum_raw[N-1:0];
   assign diff    = (u >= vw) ? (u - vw) : N'({1'b0, u} + QS - {1'b0, vw});
endmodule

// File: rtl/ntt_iter.sv
// Iterative forward negacyclic NTT: one butterfly stage per cycle, natural-order in,
// bit-reversed-order out, with a start/busy/done handshake.
module ntt_iter
   import ntt_iter_pkg::*;
#(
   parameter int N = 17,
   parameter int D = 8,
   parameter int Q = Q_DEF
) (
   input logic       clk,
   input logic       rst,
   ntt_iter_if.slave bus
);
   localparam int S  = stages(D);
   localparam int SW = (S > 1) ? $clog2(S) : 1;

   state_t        state_reg, state_next;
   logic [SW-1:0] stage_reg, stage_next;
   logic [N-1:0]  x_reg  [D];
   logic [N-1:0]  x_next [D];
   logic [N-1:0]  psi_tab [D];
   logic [N-1:0]  u_sel [D/2];
   logic [N-1:0]  v_sel [D/2];
   logic [N-1:0]  w_sel [D/2];
   logic [N-1:0]  sum_out  [D/2];
   logic [N-1:0]  diff_out [D/2];

   genvar gi;
   generate
      for (gi = 0; gi < D; gi++) begin : g_coef
         assign psi_tab[gi] = N'(psi_tab_val(gi, S));
         assign bus.b[gi*N +: N] = x_reg[gi];
      end
      for (gi = 0; gi < D/2; gi++) begin : g_bf
         ntt_butterfly #(.N(N), .Q(Q)) u_bf (
            .u    (u_sel[gi]),
            .v    (v_sel[gi]),
            .w    (w_sel[gi]),
            .sum  (sum_out[gi]),
            .diff (diff_out[gi])
         );
      end
   endgenerate

   // Route the stage's pairs and twiddles onto the fixed butterfly bank.
   always_comb begin
      for (int m = 0; m < D/2; m++) begin
         u_sel[m] = '0;
         v_sel[m] = '0;
         w_sel[m] = '0;
         for (int s = 0; s < S; s++) begin
            if (stage_reg == SW'(s)) begin
               u_sel[m] = x_reg[S'(pair_lo(m, s, S))];
               v_sel[m] = x_reg[S'(pair_lo(m, s, S) + (D >> (s + 1)))];
               w_sel[m] = psi_tab[S'((1 << s) + (m >> (S - 1 - s)))];
            end
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      stage_next = stage_reg;
      x_next     = x_reg;
      case (state_reg)
         IDLE, DONE: begin
            state_next = IDLE;
            if (bus.start) begin
               for (int i = 0; i < D; i++) x_next[i] = bus.a[N*i +: N];
               stage_next = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            for (int s = 0; s < S; s++) begin
               if (stage_reg == SW'(s)) begin
                  for (int m = 0; m < D/2; m++) begin
                     x_next[S'(pair_lo(m, s, S))]                  = sum_out[m];
                     x_next[S'(pair_lo(m, s, S) + (D >> (s + 1)))] = diff_out[m];
                  end
               end
            end
            if (stage_reg == SW'(S - 1)) state_next = DONE;
            else                          stage_next = stage_reg + SW'(1);
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         stage_reg <= '0;
         for (int i = 0; i < D; i++) x_reg[i] <= '0;
      end else begin
         state_reg <= state_next;
         stage_reg <= stage_next;
         x_reg     <= x_next;
      end
   end

   assign bus.busy = (state_reg == RUN);
   assign bus.done = (state_reg == DONE);
endmodule

// File: tb/tb_ntt_iter.sv
// Scoreboard bench for ntt_iter: expectations come from a direct evaluation-form NTT.
module tb_ntt_iter;
   localparam int N = 17;
   localparam int D = 8;
   localparam int Q = 7681;
   localparam int S = 3;
   localparam int W = N * D;
   localparam longint unsigned PSI = 7154;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ntt_iter_if #(.N(N), .D(D)) bus ();
   ntt_iter #(.N(N), .D(D), .Q(Q)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [W-1:0] exp_q[$];
   int total = 0;
   int bad = 0;
   int issued = 0;
   int done_seen = 0;

   function automatic int brv(input int k);
      int r;
      r = 0;
      for (int i = 0; i < S; i++) r = (r << 1) | ((k >> i) & 1);
      return r;
   endfunction

   function automatic longint unsigned pw(input int e);
      longint unsigned r;
      r = 1;
      for (int i = 0; i < (e % (2*D)); i++) r = (r * PSI) % Q;
      return r;
   endfunction

   // b[k] = sum_j a[j] * psi^((2*bitrev(k)+1)*j), i.e. evaluations at odd powers of psi.
   function automatic logic [W-1:0] ntt_ref(input logic [W-1:0] av);
      logic [W-1:0] r;
      longint unsigned acc;
      longint unsigned c;
      int i;
      r = '0;
      for (int k = 0; k < D; k++) begin
         i = brv(k);
         acc = 0;
         for (int j = 0; j < D; j++) begin
            c = longint'(av[N*j +: N]);
            acc = (acc + c * pw((2*i + 1) * j)) % Q;
         end
         r[N*k +: N] = N'(acc);
      end
      return r;
   endfunction

   function automatic logic [N-1:0] rand_coef();
      case ($urandom_range(3))
         0:       return '0;
         1:       return N'(Q - 1);
         default: return N'($urandom_range(Q - 1));
      endcase
   endfunction

   function automatic logic [W-1:0] rand_vec();
      logic [W-1:0] v;
      for (int j = 0; j < D; j++) v[N*j +: N] = rand_coef();
      return v;
   endfunction

   // Monitor: pops one expectation per done pulse.
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (!rst && bus.done) begin
            done_seen++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL extra_done: done=1 with b=%h, required no done", bus.b);
            end else begin
               e = exp_q.pop_front();
               if (bus.b !== e) begin
                  bad++;
                  $display("FAIL result: b=%h required %h", bus.b, e);
               end else begin
                  $display("txn %0d b=%h ok", done_seen, bus.b);
               end
            end
         end
      end
   end

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("idle_wait", longint'(bus.busy), 0);
   endtask

   // Issue one transform and check latency, busy length and done width.
   task automatic xform(input logic [W-1:0] av);
      int n;
      int busy_n;
      @(negedge clk);
      wait_idle();
      bus.start = 1'b1;
      bus.a     = av;
      exp_q.push_back(ntt_ref(av));
      issued++;
      @(negedge clk);
      bus.start = 1'b0;
      n = 1;
      busy_n = 0;
      while (n <= 20) begin
         if (bus.busy) busy_n++;
         if (bus.done) break;
         @(negedge clk);
         n++;
      end
      check("latency", n, S + 1);
      check("busy_cycles", busy_n, S);
      @(negedge clk);
      check("done_width", longint'(bus.done), 0);
   endtask

   initial begin
      logic [W-1:0] av;
      logic [W-1:0] bv;
      longint unsigned acc;
      int cyc;
      int last;
      int k;
      int e;

      rst = 1'b1;
      bus.start = 1'b0;
      bus.a = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", longint'(bus.busy), 0);
      check("reset_done", longint'(bus.done), 0);
      check("reset_b_zero", longint'(bus.b == '0), 1);
      rst = 1'b0;

      // Impulses and zero
      av = '0; av[0 +: N] = N'(1);
      xform(av);
      check("impulse_b0", longint'(bus.b[0 +: N]), 1);
      check("impulse_b7", longint'(bus.b[7*N +: N]), 1);
      av = '0; av[0 +: N] = N'(Q - 1);
      xform(av);
      check("impulse_neg_b3", longint'(bus.b[3*N +: N]), Q - 1);
      xform('0);

      // Reset mid-RUN: start, then assert rst for two edges while at stage 1
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = rand_vec();
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("abort_busy", longint'(bus.busy), 0);
      check("abort_done", longint'(bus.done), 0);
      check("abort_b_zero", longint'(bus.b == '0), 1);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      // Start pulse during RUN must be ignored
      @(negedge clk);
      wait_idle();
      av = rand_vec();
      bus.start = 1'b1;
      bus.a = av;
      exp_q.push_back(ntt_ref(av));
      issued++;
      @(negedge clk);
      bus.a = rand_vec();
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0;
      while (!bus.done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("ignore_start_done", longint'(bus.done), 1);
      repeat (2) @(negedge clk);

      // Back-to-back: start held high, reloaded in every DONE cycle
      @(negedge clk);
      wait_idle();
      av = rand_vec();
      bus.start = 1'b1;
      bus.a = av;
      exp_q.push_back(ntt_ref(av));
      issued++;
      last = -1;
      cyc = 0;
      k = 0;
      while (k < 6 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (bus.done) begin
            if (last >= 0) check("b2b_interval", cyc - last, S + 1);
            last = cyc;
            k++;
            if (k < 6) begin
               av = rand_vec();
               bus.a = av;
               exp_q.push_back(ntt_ref(av));
               issued++;
            end else begin
               bus.start = 1'b0;
            end
         end
      end
      check("b2b_count", k, 6);
      bus.start = 1'b0;

      // Round trip through a software inverse (scaled by D)
      av = '0;
      for (int j = 0; j < D; j++) av[N*j +: N] = N'(j + 1);
      xform(av);
      bv = bus.b;
      for (int j = 0; j < D; j++) begin
         acc = 0;
         for (int kk = 0; kk < D; kk++) begin
            e = (2*D - ((2*brv(kk) + 1) * j) % (2*D)) % (2*D);
            acc = (acc + longint'(bv[N*kk +: N]) * pw(e)) % Q;
         end
         check("round_trip", longint'(acc), 8 * (j + 1));
      end

      // Random vectors
      for (int t = 0; t < 1000; t++) xform(rand_vec());

      repeat (4) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      check("done_count", done_seen, issued);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end
endmodule
